// File: rtl/mcpi_ratio_div.sv
// mcpi_ratio_div: pi estimate 4*hits/total as a saturated fixed-point byte via restoring division
module mcpi_ratio_div #(
   parameter int W    = 8,
   parameter int FRAC = 5
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [W-1:0] hits,
   input  logic [W-1:0] total,
   output logic         busy,
   output logic         done,
   output logic [7:0]   q,
   output logic         err
);
   localparam int DW = W + 2 + FRAC;
   localparam int CW = $clog2(DW);

   typedef enum logic {IDLE, DIV} state_t;

   state_t          state;
   logic [DW-1:0]   dividend;
   logic [DW-1:0]   quot;
   logic [W:0]      rem;
   logic [W-1:0]    divisor;
   logic [CW-1:0]   cnt;
   logic            err_pend;
   logic [W:0]      r;
   logic [W:0]      diff;
   logic            ge;
   logic [DW-1:0]   quot_n;

   // one restoring step: shift in the next dividend bit, trial-subtract the divisor
   always_comb begin
      r      = (W+1)'({rem, dividend[cnt]});
      ge     = r >= {1'b0, divisor};
      diff   = r - {1'b0, divisor};
      quot_n = DW'({quot, ge});
   end

   // control and datapath; err from accept is held back until the done edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         q        <= 8'h00;
         err      <= 1'b0;
         err_pend <= 1'b0;
         dividend <= '0;
         quot     <= '0;
         rem      <= '0;
         divisor  <= '0;
         cnt      <= '0;
      end else begin
         done <= 1'b0;
         if (state == IDLE) begin
            if (start && total == '0) begin
               done <= 1'b1;
               err  <= 1'b1;
               q    <= 8'h00;
            end else if (start) begin
               dividend <= {hits, {(2+FRAC){1'b0}}};
               divisor  <= total;
               rem      <= '0;
               quot     <= '0;
               cnt      <= CW'(DW-1);
               err_pend <= hits > total;
               busy     <= 1'b1;
               state    <= DIV;
            end
         end else begin
            rem  <= ge ? diff : r;
            quot <= quot_n;
            cnt  <= cnt - 1'b1;
            if (cnt == '0) begin
               busy  <= 1'b0;
               done  <= 1'b1;
               err   <= err_pend;
               q     <= |quot_n[DW-1:8] ? 8'hFF : quot_n[7:0];
               state <= IDLE;
            end
         end
      end
   end
endmodule
